// File: rtl/axi4_pkg.sv
// Shared AXI4-Stream types for the stream checker and its buffer.
package axi4_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_DEST_W = 4;

  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [AXI_DEST_W-1:0] axi_dest_t;

  // Receive progress of the checker for one packet
  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } axis_chk_state_t;

  // Marker in first_err_idx meaning no mismatching beat seen yet
  localparam logic [7:0] NO_ERR_IDX = 8'hFF;

  // Error counter ceiling
  localparam logic [15:0] ERR_MAX = 16'hFFFF;

endpackage

// File: rtl/axis_chk_buffer.sv
// DEPTH x 64 simple dual-port capture buffer: one write port fed by the
// stream handshake, one registered read port for post-mortem inspection.
module axis_chk_buffer
  import axi4_pkg::*;
#(
  parameter int DEPTH = 24
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  axi_data_t                wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output axi_data_t                rd_data
);

  axi_data_t mem [DEPTH];
  axi_data_t rdData_q;

  // Capture each accepted beat; contents are not cleared by reset
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, zeroed by reset so the output starts defined
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdData_q <= '0;
    end else begin
      rdData_q <= mem[rd_addr];
    end
  end

  assign rd_data = rdData_q;

endmodule

// File: rtl/axi4s_stream_checker.sv
// AXI4-Stream receive endpoint: accepts one DEPTH-beat packet, stores it,
// checks each beat against BASE+index / EXP_DEST / tlast position, and
// reports pass/fail with an error count and first failing index.
module axi4s_stream_checker
  import axi4_pkg::*;
#(
  parameter int        DEPTH     = 24,
  parameter axi_data_t BASE      = 64'hdeadbeef00000000,
  parameter axi_dest_t EXP_DEST  = '0,
  parameter logic [7:0] READY_PAT = 8'hFF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       axis_tvalid,
  output logic                       axis_tready,
  input  axi_data_t                  axis_tdata,
  input  axi_dest_t                  axis_tdest,
  input  logic                       axis_tlast,
  input  logic                       clear,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH+1)-1:0] beat_count,
  output logic [15:0]                err_count,
  output logic [7:0]                 first_err_idx,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output axi_data_t                  rd_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  axis_chk_state_t state_q, state_d;
  logic [2:0]      slot_q;
  logic [CW-1:0]   beatCount_q, beatCount_d;
  logic [15:0]     errCount_q, errCount_d;
  logic [7:0]      firstErr_q, firstErr_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic      handshake;
  axi_data_t expData;
  logic      isLastIdx;
  logic      beatErr;

  // Backpressure comes from the free-running slot counter; reset forces it low
  assign axis_tready = !RST && (state_q != DONE) && READY_PAT[slot_q];
  assign handshake   = axis_tvalid && axis_tready;

  assign expData   = BASE + axi_data_t'(beatCount_q);
  assign isLastIdx = (beatCount_q == CW'(DEPTH - 1));
  assign beatErr   = (axis_tdata != expData) ||
                     (axis_tdest != EXP_DEST) ||
                     (axis_tlast != isLastIdx);

  // Next-state logic: score accepted beats, finish on last index or tlast,
  // re-arm only from DONE on clear
  always_comb begin
    state_d     = state_q;
    beatCount_d = beatCount_q;
    errCount_d  = errCount_q;
    firstErr_d  = firstErr_q;
    done_d      = done_q;
    pass_d      = pass_q;
    case (state_q)
      IDLE, RECV: begin
        if (handshake) begin
          beatCount_d = beatCount_q + CW'(1);
          if (beatErr) begin
            if (errCount_q != ERR_MAX) begin
              errCount_d = errCount_q + 16'd1;
            end
            if (firstErr_q == NO_ERR_IDX) begin
              firstErr_d = 8'(beatCount_q);
            end
          end
          if (isLastIdx || axis_tlast) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (errCount_d == 16'd0);
          end else begin
            state_d = RECV;
          end
        end
      end
      DONE: begin
        if (clear) begin
          state_d     = IDLE;
          beatCount_d = '0;
          errCount_d  = '0;
          firstErr_d  = NO_ERR_IDX;
          done_d      = 1'b0;
          pass_d      = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and the backpressure slot, all synchronously reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      beatCount_q <= '0;
      errCount_q  <= '0;
      firstErr_q  <= NO_ERR_IDX;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_q + 3'd1;
      beatCount_q <= beatCount_d;
      errCount_q  <= errCount_d;
      firstErr_q  <= firstErr_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  axis_chk_buffer #(
    .DEPTH(DEPTH)
  ) uBuffer (
    .CLK    (CLK),
    .RST    (RST),
    .wr_en  (handshake),
    .wr_addr(beatCount_q[AW-1:0]),
    .wr_data(axis_tdata),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign done          = done_q;
  assign pass          = pass_q;
  assign beat_count    = beatCount_q;
  assign err_count     = errCount_q;
  assign first_err_idx = firstErr_q;

endmodule

// File: tb/tb_axi4s_stream_checker.sv
// Directed bench for axi4s_stream_checker: a table of packet scenarios plus
// hand-written reset / clear sequences. Two instances differ only in
// READY_PAT; the stream source follows whichever one is under test.
module tb_axi4s_stream_checker;

  localparam int DEPTH = 24;
  localparam logic [63:0] BASE = 64'hdeadbeef00000000;

  logic        CLK;
  logic        RST;
  logic        tvalid;
  logic [63:0] tdata;
  logic [3:0]  tdest;
  logic        tlast;
  logic        clear;
  logic [4:0]  rdAddr;

  logic        tReadyA, doneA, passA;
  logic [4:0]  beatsA;
  logic [15:0] errA;
  logic [7:0]  firstA;
  logic [63:0] rdDataA;

  logic        tReadyB, doneB, passB;
  logic [4:0]  beatsB;
  logic [15:0] errB;
  logic [7:0]  firstB;
  logic [63:0] rdDataB;

  int passed = 0;
  int total  = 0;

  axi4s_stream_checker #(
    .DEPTH(DEPTH), .BASE(BASE), .EXP_DEST(4'd0), .READY_PAT(8'hFF)
  ) dutA (
    .CLK(CLK), .RST(RST),
    .axis_tvalid(tvalid), .axis_tready(tReadyA), .axis_tdata(tdata),
    .axis_tdest(tdest), .axis_tlast(tlast), .clear(clear),
    .done(doneA), .pass(passA), .beat_count(beatsA), .err_count(errA),
    .first_err_idx(firstA), .rd_addr(rdAddr), .rd_data(rdDataA)
  );

  axi4s_stream_checker #(
    .DEPTH(DEPTH), .BASE(BASE), .EXP_DEST(4'd0), .READY_PAT(8'b01010101)
  ) dutB (
    .CLK(CLK), .RST(RST),
    .axis_tvalid(tvalid), .axis_tready(tReadyB), .axis_tdata(tdata),
    .axis_tdest(tdest), .axis_tlast(tlast), .clear(clear),
    .done(doneB), .pass(passB), .beat_count(beatsB), .err_count(errB),
    .first_err_idx(firstB), .rd_addr(rdAddr), .rd_data(rdDataB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    bit          useB;
    int          badIdx;
    logic [63:0] badData;
    int          lastIdx;
    logic [3:0]  dest;
    int          expCycles;
    logic        expPass;
    logic [15:0] expErr;
    logic [7:0]  expFirst;
    logic [4:0]  expBeats;
    logic [4:0]  peekAddr;
    logic [63:0] expPeek;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RST    = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    clear  = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  // Streams beats 0..lastIdx (at most maxBeats handshakes) into the selected
  // instance; cyc is the 1-based cycle in which done is first seen
  task automatic runPacket(input bit useB, input int badIdx,
                           input logic [63:0] badData, input int lastIdx,
                           input logic [3:0] dest, input int maxBeats,
                           output int cyc);
    int  i  = 0;
    int  it = 0;
    bit  hs;
    bit  dn = 1'b0;
    cyc = 0;
    while (!dn && i < maxBeats && it < 200) begin
      tvalid = 1'b1;
      tdata  = (i == badIdx) ? badData : BASE + 64'(i);
      tdest  = dest;
      tlast  = (i == lastIdx);
      #1;
      hs = useB ? tReadyB : tReadyA;
      tick();
      it++;
      if (hs) i++;
      dn = useB ? doneB : doneA;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (dn) cyc = it + 1;
    if (it >= 200) begin
      total++;
      $display("[TB] FAIL timeout: got %0d beats, expected %0d", i, maxBeats);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int          cyc;
    logic        dn, ps, rdy;
    logic [15:0] er;
    logic [7:0]  fe;
    logic [4:0]  bc;
    logic [63:0] rd;
    doReset();
    runPacket(v.useB, v.badIdx, v.badData, v.lastIdx, v.dest, DEPTH, cyc);
    dn  = v.useB ? doneB   : doneA;
    ps  = v.useB ? passB   : passA;
    er  = v.useB ? errB    : errA;
    fe  = v.useB ? firstB  : firstA;
    bc  = v.useB ? beatsB  : beatsA;
    rdy = v.useB ? tReadyB : tReadyA;
    checkOutput({v.name, " done"}, 64'(dn), 64'(1'b1));
    checkOutput({v.name, " cycles"}, 64'(cyc), 64'(v.expCycles));
    checkOutput({v.name, " pass"}, 64'(ps), 64'(v.expPass));
    checkOutput({v.name, " err_count"}, 64'(er), 64'(v.expErr));
    checkOutput({v.name, " first_err_idx"}, 64'(fe), 64'(v.expFirst));
    checkOutput({v.name, " beat_count"}, 64'(bc), 64'(v.expBeats));
    checkOutput({v.name, " tready in DONE"}, 64'(rdy), 64'(1'b0));
    rdAddr = v.peekAddr;
    tick();
    rd = v.useB ? rdDataB : rdDataA;
    checkOutput({v.name, " rd_data"}, rd, v.expPeek);
  endtask

  initial begin
    int cyc;

    vecs[0] = '{"clean_ff", 1'b0, -1, 64'h0, 23, 4'd0, 25, 1'b1, 16'd0,
                8'hFF, 5'd24, 5'd5, 64'hdeadbeef00000005};
    vecs[1] = '{"clean_55", 1'b1, -1, 64'h0, 23, 4'd0, 48, 1'b1, 16'd0,
                8'hFF, 5'd24, 5'd17, 64'hdeadbeef00000011};
    vecs[2] = '{"bad_beat7", 1'b0, 7, 64'hdeadbeef000000FF, 23, 4'd0, 25,
                1'b0, 16'd1, 8'd7, 5'd24, 5'd7, 64'hdeadbeef000000FF};
    vecs[3] = '{"early_tlast", 1'b0, -1, 64'h0, 9, 4'd0, 11, 1'b0, 16'd1,
                8'd9, 5'd10, 5'd9, 64'hdeadbeef00000009};
    vecs[4] = '{"dest3", 1'b0, -1, 64'h0, 23, 4'd3, 25, 1'b0, 16'd24,
                8'd0, 5'd24, 5'd23, 64'hdeadbeef00000017};

    RST    = 1'b1;
    tvalid = 1'b0;
    tdata  = '0;
    tdest  = '0;
    tlast  = 1'b0;
    clear  = 1'b0;
    rdAddr = '0;

    // Reset state, sampled while RST is still asserted
    tick();
    tick();
    checkOutput("reset tready", 64'(tReadyA), 64'(1'b0));
    checkOutput("reset done", 64'(doneA), 64'(1'b0));
    checkOutput("reset pass", 64'(passA), 64'(1'b0));
    checkOutput("reset beat_count", 64'(beatsA), 64'd0);
    checkOutput("reset err_count", 64'(errA), 64'd0);
    checkOutput("reset first_err_idx", 64'(firstA), 64'hFF);
    checkOutput("reset rd_data", rdDataA, 64'd0);
    RST = 1'b0;

    for (int k = 0; k < 5; k++) begin
      applyStimulus(vecs[k]);
    end

    // Partial packet, clear outside DONE ignored, then RST mid-packet
    doReset();
    runPacket(1'b0, -1, 64'h0, 23, 4'd0, 13, cyc);
    checkOutput("partial beat_count", 64'(beatsA), 64'd13);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clear ignored beat_count", 64'(beatsA), 64'd13);
    checkOutput("clear ignored done", 64'(doneA), 64'(1'b0));
    doReset();
    checkOutput("mid rst beat_count", 64'(beatsA), 64'd0);
    checkOutput("mid rst err_count", 64'(errA), 64'd0);
    checkOutput("mid rst first_err_idx", 64'(firstA), 64'hFF);

    runPacket(1'b0, -1, 64'h0, 23, 4'd0, DEPTH, cyc);
    checkOutput("after rst cycles", 64'(cyc), 64'd25);
    checkOutput("after rst pass", 64'(passA), 64'(1'b1));

    // clear together with tvalid in DONE: clear wins, beat not taken
    clear  = 1'b1;
    tvalid = 1'b1;
    tdata  = BASE;
    tdest  = 4'd0;
    #1;
    checkOutput("clear+valid tready", 64'(tReadyA), 64'(1'b0));
    tick();
    clear  = 1'b0;
    tvalid = 1'b0;
    checkOutput("cleared done", 64'(doneA), 64'(1'b0));
    checkOutput("cleared pass", 64'(passA), 64'(1'b0));
    checkOutput("cleared beat_count", 64'(beatsA), 64'd0);
    checkOutput("cleared first_err_idx", 64'(firstA), 64'hFF);

    runPacket(1'b0, -1, 64'h0, 23, 4'd0, DEPTH, cyc);
    checkOutput("resend done", 64'(doneA), 64'(1'b1));
    checkOutput("resend pass", 64'(passA), 64'(1'b1));
    checkOutput("resend err_count", 64'(errA), 64'd0);
    checkOutput("resend beat_count", 64'(beatsA), 64'd24);
    rdAddr = 5'd0;
    tick();
    checkOutput("resend rd_data", rdDataA, BASE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi4s_stream_checker.md
# axi4s_stream_checker

Synthesizable AXI4-Stream receive endpoint that sits on a slave port of the NoC stream wrapper, opposite a stream master device. Accepts one packet of `DEPTH` beats, stores each beat in an internal buffer, checks every beat against the incremental pattern `BASE + index` and the expected destination, and reports pass/fail plus error counts. Programmable backpressure exercises the network's stall paths.

## Interface
- `DEPTH`, 24: beats per packet; also the buffer depth (2..256).
- `BASE`, 64'hdeadbeef00000000: expected data of beat 0; beat i expects `BASE + i` (mod 2^64).
- `EXP_DEST`, 0: expected `tdest` on every beat.
- `READY_PAT`, 8'hFF: backpressure mask; bit k gates `tready` in pattern slot k.

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `axis_tvalid`  in  1  beat valid.
- `axis_tready`  out  1  beat accept.
- `axis_tdata`  in  64 (`axi_data_t`)  beat data.
- `axis_tdest`  in  `axi_dest_t`  routed destination.
- `axis_tlast`  in  1  final beat of packet.
- `clear`  in  1  one-cycle pulse; re-arms checker from DONE.
- `done`  out  1  packet complete (held until `clear`/`RST`).
- `pass`  out  1  valid when `done`; 1 iff `err_count == 0`.
- `beat_count`  out  $clog2(DEPTH+1)  beats accepted.
- `err_count`  out  16  data+dest+tlast mismatches, saturating at 16'hFFFF.
- `first_err_idx`  out  8  index of first mismatching beat; 8'hFF if none.
- `rd_addr`  in  $clog2(DEPTH)  buffer read address.
- `rd_data`  out  64  buffer word, one-cycle read latency.

## Operation
- States: IDLE -> RECV -> DONE. IDLE: no beat yet; RECV: ≥1 beat accepted; DONE: stop accepting.
- `axis_tready = (state != DONE) && READY_PAT[slot]`; `slot` is a 3-bit counter incremented every cycle outside reset, so tready is combinational only from registered state.
- Handshake = `tvalid && tready`. On handshake: `buffer[beat_count] <= tdata`; compare `tdata` to `BASE + beat_count`, `tdest` to `EXP_DEST`, and `tlast` to `(beat_count == DEPTH-1)`; any mismatch adds exactly 1 to `err_count`; records `first_err_idx` if still 8'hFF; `beat_count++`.
- IDLE -> RECV on first handshake. RECV/IDLE -> DONE on a handshake that is beat `DEPTH-1` or carries `tlast` (early tlast terminates the packet, counted as error).
- DONE -> IDLE on `clear`: counters, `first_err_idx`, `done` reset; buffer contents retained. `clear` outside DONE is ignored.
- Master must hold `tdata/tdest/tlast` stable while `tvalid && !tready`; checker does not verify this.

## Timing
- Reset values: `axis_tready` 0 during RST cycle, `done` 0, `pass` 0, `beat_count` 0, `err_count` 0, `first_err_idx` 8'hFF, `slot` 0, state IDLE. `rd_data` 0.
- Counters/flags update at the edge that completes the handshake; `done` asserts the cycle after the final handshake; `tready` deasserts in that same cycle.
- `pass = done && (err_count == 0)`, registered with `done`.
- RST mid-packet: all state returns to reset values next edge; partial packet discarded; buffer contents undefined.
- Simultaneous `clear` and `tvalid` in DONE: clear wins; beat not accepted that cycle (tready 0 in DONE).

## Structure
- `axi_data_t`, `axi_dest_t` from `axi4_pkg`; add `axis_chk_state_t` enum (IDLE, RECV, DONE) to `axi4_pkg`.
- One sub-module: `axis_chk_buffer` (DEPTH x 64 simple dual-port RAM, synchronous write on handshake, registered read).

## Test plan
- 24 beats `deadbeef00000000..deadbeef00000017`, dest 0, tlast on beat 23, tvalid continuous, READY_PAT FF -> `done` at cycle 25 after first beat, `pass`=1, `err_count`=0, `rd_data` at addr 5 = `deadbeef00000005`.
- Same stream, READY_PAT 8'b01010101 -> accepted every other cycle, `done` after 48 cycles, `pass`=1.
- Beat 7 data `...0000FF` -> `err_count`=1, `first_err_idx`=7, `pass`=0.
- tlast on beat 9 -> DONE with `beat_count`=10, `err_count`=1, `first_err_idx`=9.
- Wrong dest 3 on all beats -> `err_count`=24, `first_err_idx`=0.
- RST asserted after beat 12, then `clear` in DONE, then resend full packet -> counters zero after RST; second packet passes.
